fetch_ctrl: RTL

Instruction-fetch controller that sequences the synchronous instruction memory. It owns the fetch PC, drives it to the memory's `pc` input, and captures the returned word one cycle later. It buffers fetched words in a small FIFO and hands `{pc, instr}` pairs to decode over a valid/ready handshake. It also handles redirects (branches, jumps, traps) by flushing in-flight and buffered fetches.

---
 rtl/fetch_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, drives a synchronous imem, and buffers
// {pc, instr} pairs for decode. Optional misaligned-redirect trap via FETCH_MISALIGN_TRAP_EN.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned DWORD_BITS = 64,
  localparam int unsigned WORD_BITS  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [DWORD_BITS-1:0] imem_pc_o,
  input  logic [WORD_BITS-1:0]  imem_instr_i,
  input  logic                  redirect_valid_i,
  input  logic [DWORD_BITS-1:0] redirect_pc_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WORD_BITS-1:0]  out_instr_o,
  output logic [DWORD_BITS-1:0] out_pc_o,
  output logic                  fault_o,
  output logic [DWORD_BITS-1:0] fault_pc_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;

  typedef enum logic [0:0] {StRun, StFault} state_e;

  state_e                state_q, state_d;
  logic [DWORD_BITS-1:0] imem_pc_q, imem_pc_d;
  logic                  infl_q, infl_d;
  logic [DWORD_BITS-1:0] infl_pc_q, infl_pc_d;
  logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [DWORD_BITS-1:0] fault_pc_q, fault_pc_d;
  logic [DWORD_BITS-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [WORD_BITS-1:0]  fifo_instr_q [FIFO_DEPTH];

  logic                  pop, push, issue, run_ok, misalign;
  logic [OccW-1:0]       occ;
  logic [DWORD_BITS-1:0] target;

  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign = (redirect_pc_i[1:0] != 2'b00);
    target   = redirect_pc_i;
`else
    misalign = 1'b0;
    target   = redirect_pc_i & ~64'h3;
`endif
  end

  assign out_valid_o = (count_q != '0);
  assign out_pc_o    = fifo_pc_q[head_q];
  assign out_instr_o = fifo_instr_q[head_q];
  assign fault_o     = (state_q == StFault);
  assign fault_pc_o  = fault_pc_q;

  assign pop  = out_valid_o & out_ready_i;
  assign push = infl_q & ~redirect_valid_i;
  // Credit check: slots already owed to buffered and in-flight words, minus the one leaving.
  assign occ  = OccW'(count_q) + OccW'(infl_q) - OccW'(pop);

  always_comb begin
    run_ok = 1'b0;
    unique case (state_q)
      StRun:   run_ok = 1'b1;
      StFault: run_ok = 1'b0;
      default: run_ok = 1'b0;
    endcase
  end

  assign issue = run_ok & ~redirect_valid_i & (occ < OccW'(FIFO_DEPTH));

  always_comb begin
    state_d    = state_q;
    imem_pc_d  = imem_pc_q;
    infl_d     = 1'b0;
    infl_pc_d  = infl_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fault_pc_d = fault_pc_q;
    if (redirect_valid_i) begin
      imem_pc_d  = target;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      state_d    = misalign ? StFault : StRun;
      fault_pc_d = misalign ? redirect_pc_i : '0;
    end else begin
      if (issue) begin
        infl_d    = 1'b1;
        infl_pc_d = imem_pc_q;
        imem_pc_d = imem_pc_q + 64'd4;
      end
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StRun;
      imem_pc_q  <= RESET_PC;
      infl_q     <= 1'b0;
      infl_pc_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      imem_pc_q  <= imem_pc_d;
      infl_q     <= infl_d;
      infl_pc_q  <= infl_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else if (push) begin
      fifo_pc_q[tail_q]    <= infl_pc_q;
      fifo_instr_q[tail_q] <= imem_instr_i;
    end
  end

  assign imem_pc_o = imem_pc_q;

endmodule
